armleocpu_divider: RTL and testbench

Iterative 32-bit integer divider implementing RISC-V M-extension DIV/DIVU/REM/REMU semantics. It sits in the execute stage between register-file read and writeback: it takes rs1/rs2 read data as dividend/divisor and produces a quotient and remainder that the writeback logic selects for rd. It uses one restoring-division step per cycle and has a fast path for divide-by-zero.

---
 rtl/armleocpu_divider_pkg.sv | 19 +
 rtl/armleocpu_divider.sv | 115 +++++++++++
 tb/tb_armleocpu_divider.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/armleocpu_divider_pkg.sv
// Shared divider constants: datapath width, FSM state encodings and the
// magnitude helper used when latching signed operands.
package armleocpu_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Absolute value as an unsigned 32-bit number; 0x80000000 maps to itself.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x,
                                                       input logic isSigned);
        return (isSigned && x[DIV_WIDTH-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/armleocpu_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero bypasses the iteration.
module armleocpu_divider
    import armleocpu_divider_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch,
    input  logic                 kill,
    input  logic                 is_signed,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    div_state_t           state_q;
    logic [4:0]           count_q;
    logic [DIV_WIDTH:0]   rem_q;
    logic [DIV_WIDTH:0]   rem_d;
    logic [DIV_WIDTH-1:0] qShift_q;
    logic [DIV_WIDTH-1:0] qShift_d;
    logic [DIV_WIDTH-1:0] dvsr_q;
    logic                 qNeg_q;
    logic                 rNeg_q;
    logic [DIV_WIDTH-1:0] quotient_q;
    logic [DIV_WIDTH-1:0] remainder_q;
    logic                 dbz_q;

    logic [DIV_WIDTH:0]   remShift;
    logic [DIV_WIDTH:0]   diff;
    logic [DIV_WIDTH-1:0] qFinal;
    logic [DIV_WIDTH-1:0] rFinal;

    // One restoring step plus the sign fix-up applied when the last step lands.
    always_comb begin
        remShift = {rem_q[DIV_WIDTH-1:0], qShift_q[DIV_WIDTH-1]};
        diff     = remShift - {1'b0, dvsr_q};
        rem_d    = remShift;
        qShift_d = {qShift_q[DIV_WIDTH-2:0], 1'b0};
        if (!diff[DIV_WIDTH]) begin
            rem_d    = diff;
            qShift_d = {qShift_q[DIV_WIDTH-2:0], 1'b1};
        end
        qFinal = qNeg_q ? -qShift_d : qShift_d;
        rFinal = rNeg_q ? -rem_d[DIV_WIDTH-1:0] : rem_d[DIV_WIDTH-1:0];
    end

    // Control FSM and datapath registers; reset beats kill, kill beats fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            count_q     <= 5'd0;
            rem_q       <= '0;
            qShift_q    <= '0;
            dvsr_q      <= '0;
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (kill) begin
            state_q <= DIV_IDLE;
            count_q <= 5'd0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (fetch) begin
                        if (divisor == '0) begin
                            state_q     <= DIV_DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q  <= DIV_CALC;
                            count_q  <= 5'd0;
                            rem_q    <= '0;
                            qShift_q <= magnitude(dividend, is_signed);
                            dvsr_q   <= magnitude(divisor, is_signed);
                            qNeg_q   <= is_signed & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
                            rNeg_q   <= is_signed & dividend[DIV_WIDTH-1];
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q    <= rem_d;
                    qShift_q <= qShift_d;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q     <= DIV_DONE;
                        quotient_q  <= qFinal;
                        remainder_q <= rFinal;
                        dbz_q       <= 1'b0;
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign ready       = (state_q == DIV_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_armleocpu_divider.sv
// Directed bench for armleocpu_divider: table of hand-computed vectors plus
// hand-written kill, reset and fetch-while-busy sequences.
module tb_armleocpu_divider;

    logic        clk;
    logic        rst_n;
    logic        fetch;
    logic        kill;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        isSigned;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expQ;
        logic [31:0] expR;
        logic        expDbz;
        int          expLat;
    } vector_t;

    vector_t vectors[9];

    armleocpu_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch),
        .kill       (kill),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch and wait (bounded) for ready; lat counts edges from the fetch edge.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        fetch     = 1'b1;
        nextCycle();
        fetch = 1'b0;
        checkOutput("busyAfterFetch", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!ready && lat < 100) begin
            nextCycle();
            lat++;
        end
    endtask

    // Ready must drop and busy must clear on the edge after the result cycle.
    task automatic checkRetire();
        nextCycle();
        checkOutput("readyPulseWidth", {31'd0, ready}, 32'd0);
        checkOutput("busyAfterReady", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int readyCount;
        logic [31:0] capQ;
        logic [31:0] capR;

        vectors[0] = '{"u100div7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vectors[1] = '{"sNeg7div2",  1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
        vectors[2] = '{"s7divNeg2",  1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
        vectors[3] = '{"u5div0",     1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vectors[4] = '{"s5div0",     1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vectors[5] = '{"uMaxDiv1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
        vectors[6] = '{"sNegDivPos", 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
        vectors[7] = '{"sOverflow",  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
        vectors[8] = '{"uOverflow",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};

        rst_n     = 1'b0;
        fetch     = 1'b0;
        kill      = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        nextCycle();
        nextCycle();
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetReady", {31'd0, ready}, 32'd0);
        checkOutput("resetQuotient", quotient, 32'd0);
        checkOutput("resetRemainder", remainder, 32'd0);
        checkOutput("resetDbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].isSigned, vectors[i].a, vectors[i].b, lat);
            checkOutput({vectors[i].name, "_latency"}, lat, vectors[i].expLat);
            checkOutput({vectors[i].name, "_quotient"}, quotient, vectors[i].expQ);
            checkOutput({vectors[i].name, "_remainder"}, remainder, vectors[i].expR);
            checkOutput({vectors[i].name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, vectors[i].expDbz});
            checkRetire();
        end

        // Kill mid-calculation: no ready, busy drops, previous result survives.
        is_signed  = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        fetch      = 1'b1;
        nextCycle();
        fetch      = 1'b0;
        readyCount = 0;
        for (int c = 0; c < 9; c++) begin
            if (ready) readyCount++;
            nextCycle();
        end
        kill = 1'b1;
        nextCycle();
        kill = 1'b0;
        checkOutput("killBusy", {31'd0, busy}, 32'd0);
        checkOutput("killReady", {31'd0, ready}, 32'd0);
        checkOutput("killQuotient", quotient, 32'd0);
        checkOutput("killRemainder", remainder, 32'h80000000);
        for (int c = 0; c < 40; c++) begin
            if (ready) readyCount++;
            nextCycle();
        end
        checkOutput("killNoReady", readyCount, 0);

        // Reset mid-calculation clears everything; the next operation still works.
        fetch = 1'b1;
        nextCycle();
        fetch = 1'b0;
        for (int c = 0; c < 9; c++) nextCycle();
        rst_n = 1'b0;
        nextCycle();
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstReady", {31'd0, ready}, 32'd0);
        checkOutput("rstQuotient", quotient, 32'd0);
        checkOutput("rstRemainder", remainder, 32'd0);
        checkOutput("rstDbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 32'd9, 32'd3, lat);
        checkOutput("after_rst_latency", lat, 33);
        checkOutput("after_rst_quotient", quotient, 32'd3);
        checkOutput("after_rst_remainder", remainder, 32'd0);
        checkRetire();

        // Fetch during CALC must be ignored: one ready, original operands' result.
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        fetch     = 1'b1;
        nextCycle();
        fetch      = 1'b0;
        lat        = 1;
        readyCount = 0;
        capQ       = '0;
        capR       = '0;
        for (int c = 1; c < 60; c++) begin
            if (c == 5) begin
                fetch     = 1'b1;
                is_signed = 1'b1;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end
            if (c == 7) fetch = 1'b0;
            if (ready) begin
                readyCount++;
                if (readyCount == 1) begin
                    lat  = c;
                    capQ = quotient;
                    capR = remainder;
                end
            end
            nextCycle();
        end
        checkOutput("ignoreFetch_pulses", readyCount, 1);
        checkOutput("ignoreFetch_latency", lat, 33);
        checkOutput("ignoreFetch_quotient", capQ, 32'd14);
        checkOutput("ignoreFetch_remainder", capR, 32'd2);
        checkOutput("ignoreFetch_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
